// File: rtl/pv2long_mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one in-order memory port between imem (port 0)
// and dmem (port 1); a source FIFO routes each in-order response back to its requester.
module pv2long_mem_port_arbiter #(
  parameter  int p_addr_sz    = 32,
  parameter  int p_data_sz    = 32,
  parameter  int p_max_outstd = 4,
  localparam int c_len_sz     = $clog2(p_data_sz/8),
  localparam int c_req_sz     = 1 + p_addr_sz + c_len_sz + p_data_sz,
  localparam int c_resp_sz    = 1 + c_len_sz + p_data_sz,
  localparam int c_ptr_sz     = $clog2(p_max_outstd),
  localparam int c_cnt_sz     = c_ptr_sz + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [c_req_sz-1:0]  req0_msg,
  input  logic                 req0_val,
  output logic                 req0_rdy,
  output logic [c_resp_sz-1:0] resp0_msg,
  output logic                 resp0_val,
  input  logic [c_req_sz-1:0]  req1_msg,
  input  logic                 req1_val,
  output logic                 req1_rdy,
  output logic [c_resp_sz-1:0] resp1_msg,
  output logic                 resp1_val,
  output logic [c_req_sz-1:0]  memreq_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  input  logic [c_resp_sz-1:0] memresp_msg,
  input  logic                 memresp_val,
  output logic [c_cnt_sz-1:0]  num_outstd,
  output logic                 err
);

  // state  | meaning
  // S_IDLE | grant chosen combinationally each cycle from val and prio
  // S_HOLD | memory stalled a request; grant locked to r_gnt_q until memreq_rdy
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              r_state, w_nxt_state;
  logic                r_prio;
  logic                r_gnt_q, w_nxt_gnt_q;
  logic                r_fifo [p_max_outstd];
  logic [c_ptr_sz-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_sz-1:0] r_cnt;
  logic                r_err;

  logic w_gnt, w_memreq_val, w_xfer, w_full, w_empty, w_pop, w_head;

  assign w_full  = (r_cnt == c_cnt_sz'(p_max_outstd));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_pop   = memresp_val & !w_empty;
  assign w_xfer  = w_memreq_val & memreq_rdy;

  always_comb begin
    w_gnt        = r_prio;
    w_memreq_val = 1'b0;
    w_nxt_state  = r_state;
    w_nxt_gnt_q  = r_gnt_q;
    case (r_state)
      S_IDLE: begin
        if (req0_val && !req1_val)      w_gnt = 1'b0;
        else if (req1_val && !req0_val) w_gnt = 1'b1;
        else                            w_gnt = r_prio;
        w_memreq_val = (req0_val | req1_val) & !w_full;
        if (w_memreq_val && !memreq_rdy) begin
          w_nxt_state = S_HOLD;
          w_nxt_gnt_q = w_gnt;
        end
      end
      S_HOLD: begin
        w_gnt        = r_gnt_q;
        w_memreq_val = 1'b1;
        if (memreq_rdy) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held, even with inputs active.
  assign memreq_val = w_memreq_val & !reset;
  assign memreq_msg = w_gnt ? req1_msg : req0_msg;
  assign req0_rdy   = !reset & w_xfer & !w_gnt;
  assign req1_rdy   = !reset & w_xfer & w_gnt;
  assign resp0_val  = !reset & w_pop & !w_head;
  assign resp1_val  = !reset & w_pop & w_head;
  assign resp0_msg  = memresp_msg;
  assign resp1_msg  = memresp_msg;
  assign num_outstd = r_cnt;
  assign err        = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_prio   <= 1'b0;
      r_gnt_q  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < p_max_outstd; i++) r_fifo[i] <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt_q <= w_nxt_gnt_q;
      if (w_xfer) begin
        r_fifo[r_wr_ptr] <= w_gnt;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
        r_prio           <= ~w_gnt;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (memresp_val && w_empty) r_err <= 1'b1;
    end
  end

endmodule
